// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch against the load/store
// buffer on the shared 8-bit RAM/IO port and assembles little-endian read words.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        go_work,
    input  logic        l_or_s,
    input  logic [2:0]  width,
    input  logic [31:0] address,
    input  logic [31:0] value_store,
    output logic        received,
    output logic        has_result,
    output logic [31:0] value_load
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

    state_t      state_q;
    logic        last_lsb_q;
    logic [2:0]  cnt_q;
    logic [1:0]  last_idx_q;
    logic [31:0] base_q;
    logic [31:0] store_q;
    logic [31:0] buf_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;
    logic        received_q;
    logic        has_result_q;
    logic        if_done_q;
    logic [31:0] value_load_q;
    logic [31:0] if_data_q;

    logic        lsb_ok;
    logic        grant_lsb;
    logic        grant_fetch;
    logic [1:0]  req_last_idx;
    logic [1:0]  prev_idx;
    logic [2:0]  cnt_d;
    logic [31:0] addr_d;
    logic [31:0] rd_word_d;

    // An IO-window store must wait for UART room; fetch may overtake it meanwhile.
    assign lsb_ok      = go_work && !(l_or_s && address[17:16] == 2'b11 && io_buffer_full);
    assign grant_lsb   = lsb_ok && (!if_req || !last_lsb_q);
    assign grant_fetch = if_req && !grant_lsb;

    always_comb begin
        req_last_idx = 2'd3;
        case (width)
            3'd1:    req_last_idx = 2'd0;
            3'd2:    req_last_idx = 2'd1;
            default: req_last_idx = 2'd3;
        endcase
    end

    assign prev_idx = cnt_q[1:0] - 2'd1;
    assign cnt_d    = cnt_q + 3'd1;
    assign addr_d   = base_q + {29'd0, cnt_d};

    // The final byte is still on mem_din during the completion cycle, so it is merged
    // combinationally there and latched for the following cycles.
    assign rd_word_d = buf_q | ({24'd0, mem_din} << {last_idx_q, 3'b000});

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            last_lsb_q   <= 1'b0;
            cnt_q        <= 3'd0;
            last_idx_q   <= 2'd0;
            base_q       <= 32'd0;
            store_q      <= 32'd0;
            buf_q        <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            received_q   <= 1'b0;
            has_result_q <= 1'b0;
            if_done_q    <= 1'b0;
            value_load_q <= 32'd0;
            if_data_q    <= 32'd0;
        end else if (rdy_in) begin
            received_q   <= 1'b0;
            has_result_q <= 1'b0;
            if_done_q    <= 1'b0;
            if (has_result_q) value_load_q <= rd_word_d;
            if (if_done_q)    if_data_q    <= rd_word_d;

            case (state_q)
                IDLE: begin
                    if (!clear_in && (grant_lsb || grant_fetch)) begin
                        cnt_q      <= 3'd0;
                        buf_q      <= 32'd0;
                        last_lsb_q <= grant_lsb;
                        base_q     <= grant_lsb ? address : if_addr;
                        mem_a_q    <= grant_lsb ? address : if_addr;
                        if (grant_lsb) begin
                            received_q <= 1'b1;
                            last_idx_q <= req_last_idx;
                            store_q    <= value_store;
                            if (l_or_s) begin
                                state_q    <= STORE;
                                mem_wr_q   <= 1'b1;
                                mem_dout_q <= value_store[7:0];
                            end else begin
                                state_q <= LOAD;
                            end
                        end else begin
                            state_q    <= FETCH;
                            last_idx_q <= 2'd3;
                        end
                    end
                end
                FETCH, LOAD: begin
                    if (cnt_q != 3'd0) buf_q[{prev_idx, 3'b000} +: 8] <= mem_din;
                    if (clear_in) begin
                        state_q <= IDLE;
                    end else if (cnt_q == {1'b0, last_idx_q}) begin
                        state_q <= IDLE;
                        if (state_q == FETCH) if_done_q    <= 1'b1;
                        else                  has_result_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_d;
                        mem_a_q <= addr_d;
                    end
                end
                STORE: begin
                    // Stores ignore clear_in: once accepted they always finish.
                    if (cnt_q == {1'b0, last_idx_q}) begin
                        state_q  <= IDLE;
                        mem_wr_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_d;
                        mem_a_q    <= addr_d;
                        mem_dout_q <= store_q[{cnt_d[1:0], 3'b000} +: 8];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    assign mem_wr     = mem_wr_q & rdy_in;
    assign received   = received_q & rdy_in;
    assign has_result = has_result_q & rdy_in;
    assign if_done    = if_done_q & rdy_in;
    assign value_load = has_result_q ? rd_word_d : value_load_q;
    assign if_data    = if_done_q ? rd_word_d : if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model with one-cycle read latency and
// hand-computed expectations for fetch, load, store, arbitration, IO stall and flush.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        go_work, l_or_s;
    logic [2:0]  width;
    logic [31:0] address, value_store;
    logic        received, has_result;
    logic [31:0] value_load;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .go_work(go_work), .l_or_s(l_or_s),
        .width(width), .address(address), .value_store(value_store),
        .received(received), .has_result(has_result), .value_load(value_load)
    );

    // RAM: address sampled at the edge, byte presented during the next cycle.
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] qgetv(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lsb_req(input logic st, input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] v);
        go_work = 1'b1; l_or_s = st; width = w; address = a; value_store = v;
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
        if_req = 1'b1; if_addr = a;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq({tag, "_addr"}, mem_a, a + k);
            check_eq({tag, "_early"}, {31'd0, if_done}, 32'd0);
        end
        tick();
        check_eq({tag, "_done"}, {31'd0, if_done}, 32'd1);
        check_eq({tag, "_data"}, if_data, exp);
        if_req = 1'b0;
        tick();
        check_eq({tag, "_pulse"}, {31'd0, if_done}, 32'd0);
        check_eq({tag, "_hold"}, if_data, exp);
        $display("fetch  addr=%08h data=%08h", a, if_data);
    endtask

    int rc[$], hc[$], dc[$];
    logic [31:0] hv[$], dv[$];

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; go_work = 1'b0; l_or_s = 1'b0;
        width = 3'd0; address = 32'd0; value_store = 32'd0;

        ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
        ram[32'h2003] = 8'h80; ram[32'h2004] = 8'h7F;
        ram[32'h2010] = 8'h34; ram[32'h2011] = 8'h12; ram[32'h2012] = 8'hFF; ram[32'h2013] = 8'h00;
        ram[32'h402] = 8'h55; ram[32'h602] = 8'h77;

        // Reset state
        repeat (3) tick();
        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        check_eq("rst_pulses", {29'd0, mem_wr, received, has_result}, 32'd0);
        check_eq("rst_if_done", {31'd0, if_done}, 32'd0);
        check_eq("rst_value_load", value_load, 32'd0);
        check_eq("rst_if_data", if_data, 32'd0);
        rst_in = 1'b1;
        tick();

        // Byte load, zero-extended
        lsb_req(1'b0, 3'd1, 32'h2003, 32'd0);
        tick();
        check_eq("bload_recv", {31'd0, received}, 32'd1);
        check_eq("bload_addr", mem_a, 32'h2003);
        go_work = 1'b0;
        tick();
        check_eq("bload_recv_pulse", {31'd0, received}, 32'd0);
        check_eq("bload_has", {31'd0, has_result}, 32'd1);
        check_eq("bload_val", value_load, 32'h0000_0080);
        tick();
        check_eq("bload_has_pulse", {31'd0, has_result}, 32'd0);
        $display("load   addr=00002003 w=1 data=%08h", value_load);

        // Half load
        lsb_req(1'b0, 3'd2, 32'h2010, 32'd0);
        tick(); go_work = 1'b0;
        tick();
        check_eq("hload_early", {31'd0, has_result}, 32'd0);
        tick();
        check_eq("hload_has", {31'd0, has_result}, 32'd1);
        check_eq("hload_val", value_load, 32'h0000_1234);
        $display("load   addr=00002010 w=2 data=%08h", value_load);
        tick();

        // Half store
        lsb_req(1'b1, 3'd2, 32'h400, 32'hDEADBEEF);
        tick();
        check_eq("hst_b0", {mem_wr, received, 6'd0, mem_dout, mem_a[15:0]}, {1'b1, 1'b1, 6'd0, 8'hEF, 16'h0400});
        go_work = 1'b0;
        tick();
        check_eq("hst_b1", {mem_wr, received, 6'd0, mem_dout, mem_a[15:0]}, {1'b1, 1'b0, 6'd0, 8'hBE, 16'h0401});
        tick();
        check_eq("hst_end_wr", {31'd0, mem_wr}, 32'd0);
        tick();
        check_eq("hst_ram", {8'd0, ram_rd(32'h402), ram_rd(32'h401), ram_rd(32'h400)}, 32'h0055BEEF);
        $display("store  addr=00000400 w=2 data=deadbeef");

        // Fetches
        do_fetch("fetch100", 32'h100, 32'h0000_0013);
        do_fetch("fetch200", 32'h200, 32'h4433_2211);
        tick();

        // Contention: both requesters held (last grant was fetch)
        if_req = 1'b1; if_addr = 32'h200;
        lsb_req(1'b0, 3'd4, 32'h2010, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (received)   rc.push_back(i);
            if (has_result) begin hc.push_back(i); hv.push_back(value_load); end
            if (if_done)    begin dc.push_back(i); dv.push_back(if_data); end
            if (i == 20) begin if_req = 1'b0; go_work = 1'b0; end
        end
        check_eq("cont_nrecv", rc.size(), 32'd2);
        check_eq("cont_nhas", hc.size(), 32'd2);
        check_eq("cont_ndone", dc.size(), 32'd2);
        check_eq("cont_recv0", qget(rc, 0), 32'd1);
        check_eq("cont_has0", qget(hc, 0), 32'd5);
        check_eq("cont_done0", qget(dc, 0), 32'd10);
        check_eq("cont_recv1", qget(rc, 1), 32'd11);
        check_eq("cont_has1", qget(hc, 1), 32'd15);
        check_eq("cont_done1", qget(dc, 1), 32'd20);
        check_eq("cont_hv0", qgetv(hv, 0), 32'h00FF1234);
        check_eq("cont_dv1", qgetv(dv, 1), 32'h44332211);
        $display("contention recv=%0d has=%0d done=%0d", rc.size(), hc.size(), dc.size());
        repeat (2) tick();

        // IO backpressure: store stalls, fetch is served meanwhile
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 3'd1, 32'h30000, 32'h0000_0041);
        if_req = 1'b1; if_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            check_eq("io_no_wr", {31'd0, mem_wr}, 32'd0);
            check_eq("io_no_recv", {31'd0, received}, 32'd0);
            if (i == 5) begin
                check_eq("io_fetch_done", {31'd0, if_done}, 32'd1);
                check_eq("io_fetch_data", if_data, 32'h4433_2211);
                if_req = 1'b0;
            end
            tick();
        end
        io_buffer_full = 1'b0;
        check_eq("io_still_wait", {31'd0, mem_wr}, 32'd0);
        tick();
        check_eq("io_accept", {30'd0, received, mem_wr}, 32'd3);
        check_eq("io_addr", mem_a, 32'h30000);
        check_eq("io_dout", {24'd0, mem_dout}, 32'h41);
        go_work = 1'b0;
        tick();
        check_eq("io_end_wr", {31'd0, mem_wr}, 32'd0);
        $display("store  addr=00030000 w=1 data=00000041 (after stall)");
        tick();

        // Flush a 4-byte load in byte cycle 1
        lsb_req(1'b0, 3'd0, 32'h2010, 32'd0);
        tick();
        check_eq("fl_recv", {31'd0, received}, 32'd1);
        go_work = 1'b0;
        tick();
        check_eq("fl_b1_addr", mem_a, 32'h2011);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        check_eq("fl_no_has", {31'd0, has_result}, 32'd0);
        for (int i = 4; i <= 8; i++) begin
            tick();
            check_eq("fl_no_has", {31'd0, has_result}, 32'd0);
            if (i == 4) check_eq("fl_idle_next", mem_a, 32'h100);
        end
        check_eq("fl_fetch_done", {31'd0, if_done}, 32'd1);
        check_eq("fl_fetch_data", if_data, 32'h0000_0013);
        if_req = 1'b0;
        $display("flush  load aborted, fetch data=%08h", if_data);
        tick();

        // Flush during a store: all four bytes still written
        lsb_req(1'b1, 3'd7, 32'h500, 32'hCAFEF00D);
        tick();
        check_eq("fs_b0", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'h0D, 16'h0500});
        go_work = 1'b0;
        tick();
        check_eq("fs_b1", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'hF0, 16'h0501});
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        check_eq("fs_b2", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'hFE, 16'h0502});
        tick();
        check_eq("fs_b3", {mem_wr, 7'd0, mem_dout, mem_a[15:0]}, {1'b1, 7'd0, 8'hCA, 16'h0503});
        tick();
        check_eq("fs_end_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("fs_ram", {ram_rd(32'h503), ram_rd(32'h502), ram_rd(32'h501), ram_rd(32'h500)}, 32'hCAFEF00D);
        $display("store  addr=00000500 w=4 data=cafef00d (flush ignored)");
        tick();

        // Reset in the middle of a store
        lsb_req(1'b1, 3'd4, 32'h600, 32'h11223344);
        tick(); go_work = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
        check_eq("mrst_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("mrst_addr", mem_a, 32'd0);
        rst_in = 1'b1;
        repeat (2) tick();
        check_eq("mrst_idle_wr", {31'd0, mem_wr}, 32'd0);
        check_eq("mrst_ram", {24'd0, ram_rd(32'h602)}, 32'h77);
        $display("reset  mid-store at 0x600");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
